// File: rtl/rs_pkg.sv
// rs_pkg: GF(2^8) field definition and RS(204,188) code constants shared by
// the encoder and the decoder-side blocks.
package rs_pkg;

    localparam logic [8:0] POLY = 9'h11D;
    localparam int N = 204;
    localparam int K = 188;
    localparam int NPAR = 16;

    // g15 first, so GEN[i] is the coefficient of x^i; g16 = 1 is implicit
    localparam logic [15:0][7:0] GEN = {
        8'd59, 8'd13, 8'd104, 8'd189, 8'd68, 8'd209, 8'd30, 8'd8,
        8'd163, 8'd65, 8'd41, 8'd229, 8'd98, 8'd50, 8'd36, 8'd59
    };

    typedef enum logic {DATA, PARITY} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? POLY[7:0] : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/rs_encoder_if.sv
// rs_encoder_if: message input handshake and codeword output stream.
interface rs_encoder_if;
    logic [7:0] data_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;

    modport master (
        output data_in, in_valid,
        input  in_ready, data_out, out_valid, out_sop, out_eop
    );

    modport slave (
        input  data_in, in_valid,
        output in_ready, data_out, out_valid, out_sop, out_eop
    );
endinterface

// File: rtl/gf_mult_const.sv
// gf_mult_const: combinational GF(2^8) multiply by a fixed coefficient.
module gf_mult_const
    import rs_pkg::*;
#(
    parameter logic [7:0] C = 8'h01
) (
    input  logic [7:0] a,
    output logic [7:0] y
);
    assign y = gf_mul(a, C);
endmodule

// File: rtl/rs_encoder.sv
// rs_encoder: systematic RS(204,188) encoder, message passthrough with latency 1
// followed by 16 parity bytes shifted out of the LFSR.
module rs_encoder
    import rs_pkg::*;
(
    input logic         clk,
    input logic         reset,
    rs_encoder_if.slave bus
);
    state_t           state, state_nx;
    logic [7:0]       cnt;
    logic [15:0][7:0] par;
    logic [15:0][7:0] prod;
    logic [7:0]       fb;
    logic             accept;

    assign fb = bus.data_in ^ par[15];

    for (genvar g = 0; g < NPAR; g++) begin : gen_mul
        gf_mult_const #(.C(GEN[g])) u_mul (.a(fb), .y(prod[g]));
    end

    always_comb begin
        state_nx = state;
        bus.in_ready = 1'b0;
        accept = 1'b0;
        if (state == DATA) begin
            bus.in_ready = 1'b1;
            accept = bus.in_valid;
            state_nx = (accept && cnt == 8'(K - 1)) ? PARITY : DATA;
        end else begin
            state_nx = (cnt == 8'(NPAR - 1)) ? DATA : PARITY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= DATA;
        else state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= 8'd0;
            par <= '0;
            bus.data_out <= 8'h00;
            bus.out_valid <= 1'b0;
            bus.out_sop <= 1'b0;
            bus.out_eop <= 1'b0;
        end else if (state == PARITY) begin
            // zero fill leaves the LFSR clear for the next frame
            cnt <= (cnt == 8'(NPAR - 1)) ? 8'd0 : cnt + 8'd1;
            par <= {par[14:0], 8'h00};
            bus.data_out <= par[15];
            bus.out_valid <= 1'b1;
            bus.out_sop <= 1'b0;
            bus.out_eop <= (cnt == 8'(N - K - 1));
        end else begin
            bus.out_valid <= accept;
            bus.out_sop <= accept && cnt == 8'd0;
            bus.out_eop <= 1'b0;
            if (accept) begin
                cnt <= (cnt == 8'(K - 1)) ? 8'd0 : cnt + 8'd1;
                par <= {par[14:0], 8'h00} ^ prod;
                bus.data_out <= bus.data_in;
            end
        end
    end
endmodule

// File: doc/rs_encoder.md
RS_ENCODER -- requirements
Module: rs_encoder

Interface
REQ-001 Parameters: none; code fixed at RS(204,188), t=8, GF(2^8), field polynomial 0x11D, generator roots alpha^0..alpha^15.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset.
REQ-004 Data_In  input  8  message byte, first byte = highest-degree coefficient.
REQ-005 In_Valid  input  1  Data_In valid this cycle.
REQ-006 In_Ready  output  1  encoder accepts a byte this cycle.
REQ-007 Data_Out  output  8  codeword byte, registered.
REQ-008 Out_Valid  output  1  Data_Out valid this cycle.
REQ-009 Out_Sop  output  1  high with first byte (index 0) of a 204-byte codeword.
REQ-010 Out_Eop  output  1  high with last parity byte (index 203).

Function
REQ-011 A byte SHALL be accepted only in a cycle where In_Valid=1 and In_Ready=1.
REQ-012 States SHALL be: DATA (In_Ready=1, accept message bytes) and PARITY (In_Ready=0, emit parity).
REQ-013 In DATA, an 8-bit byte counter SHALL increment per accepted byte; after the 188th accepted byte (count 187), the state SHALL go to PARITY and the counter SHALL clear.
REQ-014 In DATA, In_Valid=0 SHALL hold the counter and the LFSR, and SHALL drive Out_Valid=0 in the next cycle.
REQ-015 Each accepted byte SHALL appear on Data_Out with Out_Valid=1 exactly one cycle later (systematic, latency 1).
REQ-016 The LFSR SHALL hold 16 parity registers P15..P0; per accepted byte: fb = Data_In XOR P15; Pi = P(i-1) XOR (g_i * fb) for i=15..1; P0 = g_0 * fb; all multiplies in GF(2^8) mod 0x11D.
REQ-017 Generator coefficients g15..g0 SHALL be 59,13,104,189,68,209,30,8,163,65,41,229,98,50,36,59 (g16=1 implicit).
REQ-018 PARITY SHALL last exactly 16 cycles, independent of In_Valid, emitting P15 first, then shifting the register toward P15 with zero fill each cycle; Out_Valid=1 in all 16 output cycles.
REQ-019 The first parity byte SHALL appear on Data_Out in the cycle immediately after the last message byte is output (no gap).
REQ-020 After the 16th parity cycle, the state SHALL return to DATA with the LFSR all-zero and the counter zero, and In_Ready=1 in that same cycle.
REQ-021 Out_Sop SHALL be high with output byte 0 only; Out_Eop SHALL be high with output byte 203 only; both SHALL be 0 when Out_Valid=0.
REQ-022 In_Valid asserted during PARITY SHALL be ignored, and the upstream source SHALL hold its byte until In_Ready=1.
REQ-023 Back-to-back frames SHALL be supported: a byte offered at the first DATA cycle is accepted and becomes byte 0 of the next codeword.

Reset
REQ-024 With Reset=0 at a clock edge, the block SHALL enter DATA with counter=0, LFSR=0, Data_Out=0, Out_Valid=0, Out_Sop=0, Out_Eop=0, and In_Ready=1 from the first cycle after Reset rises.
REQ-025 Reset asserted mid-frame, in DATA or PARITY, SHALL abort the frame with no further output bytes from it; a partial codeword SHALL never be completed.

Structure
REQ-026 A shared package rs_pkg SHALL hold: field polynomial 0x11D, N=204, K=188, NPAR=16, the generator coefficient table, and the state encoding.
REQ-027 One sub-module, gf_mult_const, SHALL implement combinational GF(2^8) multiply by a constant; it is instantiated 16 times, once per generator coefficient.
REQ-028 The same rs_pkg SHALL be used by the decoder-side blocks (syndrome, error locations) so that both ends share the field definition.

Verification
REQ-029 188 zero bytes, In_Valid held high -> 204 output bytes, all 0x00; Out_Sop on byte 0, Out_Eop on byte 203.
REQ-030 187 zero bytes then 0x01 -> parity bytes in order: 59,13,104,189,68,209,30,8,163,65,41,229,98,50,36,59.
REQ-031 Random 188-byte frame -> output fed to the team's syndrome block gives all 16 syndromes = 0; the error_Locations block reports no locations.
REQ-032 Same frame with In_Valid toggling 1/0 each cycle -> identical 204-byte codeword; In_Ready=0 for exactly 16 cycles.
REQ-033 Reset=0 pulsed at byte 100 of frame 1, then a clean frame -> no Out_Eop for frame 1; frame 2 codeword matches the golden model.
REQ-034 Two frames back-to-back with In_Valid held high -> 408 consecutive valid output cycles with no gaps; second Out_Sop exactly 204 cycles after the first.
